xnor_popcount_acc: RTL

- Consumer end of the binary-multiply datapath.
- Takes the bitwise XNOR product words, where 1 means +1 and 0 means -1, as a valid/ready stream.
- Popcounts each word and accumulates over BEATS words per dot product.
- Emits the signed dot product plus its binarized sign to the next BNN layer through an output valid/ready handshake.

---
 rtl/xnor_popcount_acc.sv | 102 ++++++++++
 1 files changed

// File: rtl/xnor_popcount_acc.sv
// ============================================================================
// Module      : xnor_popcount_acc
// Description : Popcounts XNOR product words and accumulates BEATS words into
//               a signed dot product with its binarized sign.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module xnor_popcount_acc #(
    parameter int IN_WIDTH  = 32,
    parameter int BEATS     = 4,
    parameter int ACC_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_dot,
    output logic                 out_bin
);

    localparam int c_N_TOTAL = IN_WIDTH * BEATS;
    localparam int c_ACC_W   = $clog2(c_N_TOTAL + 1);
    localparam int c_CNT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [c_CNT_W-1:0]   c_LAST_BEAT = c_CNT_W'(BEATS - 1);
    localparam logic [ACC_WIDTH-1:0] c_N_DOT     = ACC_WIDTH'(c_N_TOTAL);
    localparam logic [c_ACC_W:0]     c_N_CMP     = (c_ACC_W + 1)'(c_N_TOTAL);

    logic [c_ACC_W-1:0]   r_acc;
    logic [c_CNT_W-1:0]   r_beat_cnt;
    logic                 r_out_valid;
    logic [ACC_WIDTH-1:0] r_out_dot;
    logic                 r_out_bin;

    logic [c_ACC_W-1:0]   w_pc;
    logic [c_ACC_W-1:0]   w_sum;
    logic [ACC_WIDTH-1:0] w_sum_ext;
    logic [ACC_WIDTH-1:0] w_dot;
    logic                 w_bin;
    logic                 w_accept;
    logic                 w_last;

    always_comb begin
        w_pc = '0;
        for (int i = 0; i < IN_WIDTH; i++) begin
            w_pc = w_pc + c_ACC_W'(in_data[i]);
        end
    end

    // Map the +1/-1 count back to a signed sum: dot = 2*ones - N.
    assign w_sum     = r_acc + w_pc;
    assign w_sum_ext = ACC_WIDTH'(w_sum);
    assign w_dot     = (w_sum_ext << 1) - c_N_DOT;
    assign w_bin     = ({w_sum, 1'b0} >= c_N_CMP);

    assign in_ready  = !r_out_valid || out_ready;
    assign w_accept  = in_valid && in_ready;
    assign w_last    = (r_beat_cnt == c_LAST_BEAT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc       <= '0;
            r_beat_cnt  <= '0;
            r_out_valid <= 1'b0;
            r_out_dot   <= '0;
            r_out_bin   <= 1'b0;
        end else if (clr) begin
            r_acc       <= '0;
            r_beat_cnt  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
            // A last beat landing on the drain cycle overrides the clear above.
            if (w_accept) begin
                if (w_last) begin
                    r_out_dot   <= w_dot;
                    r_out_bin   <= w_bin;
                    r_out_valid <= 1'b1;
                    r_acc       <= '0;
                    r_beat_cnt  <= '0;
                end else begin
                    r_acc      <= w_sum;
                    r_beat_cnt <= r_beat_cnt + 1'b1;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_dot   = r_out_dot;
    assign out_bin   = r_out_bin;

endmodule

`default_nettype wire
